// File: rtl/sccb_cfg_sequencer_if.sv
// Bundle between the camera-configuration sequencer and the blocks around it:
// the power-up start pulse, the register-init ROM, the SCCB write master and
// the status outputs.
//
// Signals
//   start        one-cycle pulse that begins a configuration pass
//   rom_addr     ROM address (the ROM registers its output, one cycle latency)
//   rom_data     ROM entry {reg[15:8], data[7:0]}
//   sccb_req     write request to the SCCB master
//   sccb_ready   SCCB master idle and able to accept a request
//   sccb_dev_id  SCCB write device address (constant)
//   sccb_reg     register address of the current write
//   sccb_data    data byte of the current write
//   sccb_done    one-cycle pulse: current write finished, stop condition included
//   cfg_busy     pass in progress
//   cfg_done     sticky: pass ended on the end token
//   cfg_err      sticky: pass ran off the last ROM address without an end token
//   entry_count  SCCB writes completed in the current pass
//
// Modports
//   master  the sequencer side
//   slave   the surroundings (start source, ROM, SCCB master, status consumer)
interface sccb_cfg_sequencer_if;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_req;
  logic        sccb_ready;
  logic [7:0]  sccb_dev_id;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        sccb_done;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  entry_count;

  modport master (
    input  start, rom_data, sccb_ready, sccb_done,
    output rom_addr, sccb_req, sccb_dev_id, sccb_reg, sccb_data,
           cfg_busy, cfg_done, cfg_err, entry_count
  );

  modport slave (
    output start, rom_data, sccb_ready, sccb_done,
    input  rom_addr, sccb_req, sccb_dev_id, sccb_reg, sccb_data,
           cfg_busy, cfg_done, cfg_err, entry_count
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Camera register-init sequencer. It walks the OV7670 init ROM and turns each
// {reg, data} entry into one SCCB write request. It also interprets two
// in-band tokens:
//   16'hFFFF   end of table: the pass finishes with cfg_done set
//   16'hFF_nn  wait nn * DELAY_UNIT clock cycles, then fetch the next entry
// Every completed write is followed by GAP_CYCLES idle cycles. If the pass
// reaches ROM_LAST without an end token, it finishes with cfg_err set.
//
// Ports
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    sccb_cfg_sequencer_if.master (start, ROM, SCCB handshake, status)
//
// Parameters
//   DEV_ID      SCCB write device address driven on sccb_dev_id
//   DELAY_UNIT  clock cycles per delay-token unit
//   GAP_CYCLES  idle cycles after each completed write (must be >= 1)
//   ROM_LAST    highest ROM address that the pass may read
module sccb_cfg_sequencer #(
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned DELAY_UNIT = 100_000,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  ROM_LAST   = 8'd255
) (
  input  logic                       clk,
  input  logic                       reset,
  sccb_cfg_sequencer_if.master       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_WAIT_DONE,
    S_DELAY,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [31:0] DELAY_UNIT_W = 32'(DELAY_UNIT);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  rom_addr_q;
  logic        sccb_req_q;
  logic [7:0]  sccb_reg_q;
  logic [7:0]  sccb_data_q;
  logic        cfg_busy_q;
  logic        cfg_done_q;
  logic        cfg_err_q;
  logic [7:0]  entry_count_q;
  logic [31:0] delay_cnt_q;
  logic [15:0] gap_cnt_q;

  logic [31:0] delay_load_d;
  logic        is_end_d;
  logic        is_delay_d;
  logic        advance_d;

  // The delay length is computed at full 32-bit width so that 255 units of
  // 100_000 cycles do not wrap.
  assign delay_load_d = 32'(bus.rom_data[7:0]) * DELAY_UNIT_W;
  assign is_end_d     = (bus.rom_data == 16'hFFFF);
  assign is_delay_d   = (bus.rom_data[15:8] == 8'hFF);

  // DELAY and GAP both end by moving on to the next ROM entry (or by stopping at
  // ROM_LAST). The step is written once, after the state case.
  assign advance_d = ((state_q == S_DELAY) && (delay_cnt_q == 32'd0)) ||
                     ((state_q == S_GAP)   && (gap_cnt_q == GAP_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= 8'd0;
      sccb_req_q    <= 1'b0;
      sccb_reg_q    <= 8'd0;
      sccb_data_q   <= 8'd0;
      cfg_busy_q    <= 1'b0;
      cfg_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      entry_count_q <= 8'd0;
      delay_cnt_q   <= 32'd0;
      gap_cnt_q     <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rom_addr_q    <= 8'd0;
            entry_count_q <= 8'd0;
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            cfg_busy_q    <= 1'b1;
            state_q       <= S_FETCH;
          end
        end

        // The registered ROM output for rom_addr_q is valid in DECODE.
        S_FETCH: state_q <= S_DECODE;

        S_DECODE: begin
          if (is_end_d) begin
            cfg_done_q <= 1'b1;
            state_q    <= S_FINISH;
          end else if (is_delay_d) begin
            delay_cnt_q <= delay_load_d;
            state_q     <= S_DELAY;
          end else begin
            sccb_reg_q  <= bus.rom_data[15:8];
            sccb_data_q <= bus.rom_data[7:0];
            sccb_req_q  <= 1'b1;
            state_q     <= S_REQ;
          end
        end

        // The request stays up, with reg/data frozen, until the master takes it.
        S_REQ: begin
          if (sccb_req_q && bus.sccb_ready) begin
            sccb_req_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (bus.sccb_done) begin
            if (entry_count_q != 8'hFF) begin
              entry_count_q <= entry_count_q + 8'd1;
            end
            gap_cnt_q <= 16'd0;
            state_q   <= S_GAP;
          end
        end

        // A zero-length delay still spends one cycle here.
        S_DELAY: begin
          if (delay_cnt_q != 32'd0) begin
            delay_cnt_q <= delay_cnt_q - 32'd1;
          end
        end

        S_GAP: begin
          if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end

        S_FINISH: begin
          cfg_busy_q <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      if (advance_d) begin
        if (rom_addr_q == ROM_LAST) begin
          cfg_err_q <= 1'b1;
          state_q   <= S_FINISH;
        end else begin
          rom_addr_q <= rom_addr_q + 8'd1;
          state_q    <= S_FETCH;
        end
      end
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.sccb_req    = sccb_req_q;
  assign bus.sccb_dev_id = DEV_ID;
  assign bus.sccb_reg    = sccb_reg_q;
  assign bus.sccb_data   = sccb_data_q;
  assign bus.cfg_busy    = cfg_busy_q;
  assign bus.cfg_done    = cfg_done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.entry_count = entry_count_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Testbench for sccb_cfg_sequencer, configured with DELAY_UNIT=10,
// GAP_CYCLES=4 and ROM_LAST=7.
//
// The stimulus pushes each expected SCCB write into a queue. Each entry holds
// reg, data, the entry_count value at the time of the write, and the number of
// cycles since the previous write. A monitor takes one entry off the queue for
// every accepted request.
//
// The SCCB master model pulses done 20 cycles after it accepts a request.
// Expected spacing between two accepted writes, in cycles:
//   plain write -> write : 20 (done) + 1 + 4 (gap) + 3 (fetch/decode/req) = 28
//   write -> FF_02 -> write : 28 - 3 + 2 (fetch/decode) + 21 (delay) + 3 = 51
//   write -> FF_00 -> write : 28 - 3 + 2 + 1 (delay) + 3 = 31
module tb_sccb_cfg_sequencer;

  typedef struct {
    logic [7:0] r;
    logic [7:0] d;
    logic [7:0] cnt;
    int         gap;   // 0 = first write of a pass, no spacing check
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sccb_cfg_sequencer_if bus();

  sccb_cfg_sequencer #(
    .DEV_ID    (8'h42),
    .DELAY_UNIT(10),
    .GAP_CYCLES(4),
    .ROM_LAST  (8'd7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] rom [0:255];
  logic        ready_block;
  logic        spur_done;
  logic        model_done;
  logic        pending;
  int          done_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_count = 0;
  int   last_acc = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM: data follows the address with one cycle of latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) bus.rom_data <= 16'h0000;
    else        bus.rom_data <= rom[bus.rom_addr];
  end

  // SCCB master model: it accepts on req && ready and pulses done 20 cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_done <= 1'b0;
      pending    <= 1'b0;
      done_cnt   <= 0;
    end else begin
      model_done <= 1'b0;
      if (bus.sccb_req && bus.sccb_ready) begin
        pending  <= 1'b1;
        done_cnt <= 20;
      end else if (pending) begin
        if (done_cnt == 1) begin
          model_done <= 1'b1;
          pending    <= 1'b0;
        end else begin
          done_cnt <= done_cnt - 1;
        end
      end
    end
  end

  assign bus.sccb_ready = ~ready_block;
  assign bus.sccb_done  = model_done | spur_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] d, input logic [7:0] cnt, input int gap);
    exp_t e;
    e.r = r; e.d = d; e.cnt = cnt; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: the sample is taken between edges. req && ready here means the
  // request is accepted on the next rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && bus.sccb_req && bus.sccb_ready) begin
      $display("write #%0d reg=%02h data=%02h dev=%02h count=%0d cycle=%0d",
               acc_count, bus.sccb_reg, bus.sccb_data, bus.sccb_dev_id, bus.entry_count, cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg=%02h data=%02h, expected no write",
                 bus.sccb_reg, bus.sccb_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_reg",    32'(bus.sccb_reg),    32'(e.r));
        check("wr_data",   32'(bus.sccb_data),   32'(e.d));
        check("wr_dev_id", 32'(bus.sccb_dev_id), 32'h42);
        check("wr_count",  32'(bus.entry_count), 32'(e.cnt));
        if (e.gap != 0) check("wr_spacing", 32'(cyc - last_acc), 32'(e.gap));
      end
      last_acc = cyc;
      acc_count++;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.cfg_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.cfg_busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got cfg_busy=1, expected 0 within 3000 cycles", name);
    end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (acc_count < target) begin
      checks++;
      errors++;
      $display("FAIL acc_timeout: got %0d writes, expected %0d", acc_count, target);
    end
  endtask

  task automatic rom_fill_end();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  initial begin
    int base;
    int held;
    int n;
    reset       = 1'b0;
    bus.start   = 1'b0;
    ready_block = 1'b0;
    spur_done   = 1'b0;
    rom_fill_end();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(bus.rom_addr),    32'h0);
    check("rst_req",      32'(bus.sccb_req),    32'h0);
    check("rst_reg",      32'(bus.sccb_reg),    32'h0);
    check("rst_data",     32'(bus.sccb_data),   32'h0);
    check("rst_busy",     32'(bus.cfg_busy),    32'h0);
    check("rst_done",     32'(bus.cfg_done),    32'h0);
    check("rst_err",      32'(bus.cfg_err),     32'h0);
    check("rst_count",    32'(bus.entry_count), 32'h0);
    check("rst_dev_id",   32'(bus.sccb_dev_id), 32'h42);
    @(negedge clk);
    reset = 1'b1;

    // Soft reset, 2-unit delay, one more write, end token
    rom[0] = 16'h1280; rom[1] = 16'hFF02; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    push(8'h12, 8'h80, 8'd0, 0);
    push(8'h12, 8'h14, 8'd1, 51);
    pulse_start();
    wait_idle("basic");
    check("basic_done",     32'(bus.cfg_done),    32'h1);
    check("basic_err",      32'(bus.cfg_err),     32'h0);
    check("basic_count",    32'(bus.entry_count), 32'h2);
    check("basic_rom_addr", 32'(bus.rom_addr),    32'h3);
    check("basic_pending",  32'(exp_q.size()),    32'h0);

    // Backpressure: ready held low for 50 cycles while the request is up
    rom_fill_end();
    rom[0] = 16'h5501;
    ready_block = 1'b1;
    push(8'h55, 8'h01, 8'd0, 0);
    pulse_start();
    n = 0;
    while (!bus.sccb_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.sccb_req && bus.sccb_reg == 8'h55 && bus.sccb_data == 8'h01) held++;
    end
    check("bp_held_cycles", 32'(held), 32'd50);
    @(posedge clk);
    #1 ready_block = 1'b0;
    @(negedge clk);
    check("bp_accept_req", 32'(bus.sccb_req), 32'h1);
    @(negedge clk);
    check("bp_req_dropped", 32'(bus.sccb_req), 32'h0);
    wait_idle("bp");
    check("bp_done",  32'(bus.cfg_done),    32'h1);
    check("bp_count", 32'(bus.entry_count), 32'h1);

    // No end token: eight writes, then the error at ROM_LAST
    rom_fill_end();
    for (int i = 0; i < 8; i++) begin
      rom[i] = 16'h3A04;
      push(8'h3A, 8'h04, 8'(i), (i == 0) ? 0 : 28);
    end
    pulse_start();
    wait_idle("noend");
    check("noend_err",      32'(bus.cfg_err),     32'h1);
    check("noend_done",     32'(bus.cfg_done),    32'h0);
    check("noend_busy",     32'(bus.cfg_busy),    32'h0);
    check("noend_rom_addr", 32'(bus.rom_addr),    32'h7);
    check("noend_count",    32'(bus.entry_count), 32'h8);
    check("noend_pending",  32'(exp_q.size()),    32'h0);

    // Reset during WAIT_DONE of the third write
    push(8'h3A, 8'h04, 8'd0, 0);
    push(8'h3A, 8'h04, 8'd1, 28);
    push(8'h3A, 8'h04, 8'd2, 28);
    base = acc_count;
    pulse_start();
    wait_acc(base + 3);
    repeat (5) @(negedge clk);
    check("mid_busy_before", 32'(bus.cfg_busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req",      32'(bus.sccb_req),    32'h0);
    check("mid_rst_busy",     32'(bus.cfg_busy),    32'h0);
    check("mid_rst_count",    32'(bus.entry_count), 32'h0);
    check("mid_rst_rom_addr", 32'(bus.rom_addr),    32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_writes", 32'(acc_count - base), 32'd3);
    check("post_rst_busy",   32'(bus.cfg_busy),     32'h0);
    check("post_rst_req",    32'(bus.sccb_req),     32'h0);
    check("post_rst_pending", 32'(exp_q.size()),    32'h0);

    // Spurious done in GAP, start during a pass, zero-length delay
    rom_fill_end();
    rom[0] = 16'h3A01; rom[1] = 16'h3A02; rom[2] = 16'hFF00; rom[3] = 16'h3A03;
    push(8'h3A, 8'h01, 8'd0, 0);
    push(8'h3A, 8'h02, 8'd1, 28);
    push(8'h3A, 8'h03, 8'd2, 31);
    pulse_start();
    n = 0;
    while (!bus.sccb_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    pulse_start();
    wait_idle("spur");
    check("spur_done_flag", 32'(bus.cfg_done),    32'h1);
    check("spur_err",       32'(bus.cfg_err),     32'h0);
    check("spur_count",     32'(bus.entry_count), 32'h3);
    check("spur_rom_addr",  32'(bus.rom_addr),    32'h4);
    check("spur_pending",   32'(exp_q.size()),    32'h0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_sequencer.md
Name: sccb_cfg_sequencer

Overview:
- Upstream feeder for the SCCB write master. Walks the OV7670 register-init ROM, turns each 16-bit entry {reg, data} into one SCCB write request, and interprets the in-band delay and end-of-table tokens.
- Sits between the power-up start pulse and the SCCB master. It replaces the free-running ROM address increment with an explicit request/done handshake, so the SCCB master only serialises bytes.

Parameters:
- DEV_ID, 8'h42, SCCB write device address driven on sccb_dev_id.
- DELAY_UNIT, 100_000, clk cycles per delay unit (1 ms at 100 MHz).
- GAP_CYCLES, 16, idle clk cycles inserted after each completed write before the next ROM fetch.
- ROM_LAST, 8'd255, highest ROM address; reaching it without an end token is an error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a configuration pass.
- rom_addr  out  8  ROM address. The ROM is registered, so data is valid one cycle after the address changes.
- rom_data  in  16  ROM entry {reg[15:8], data[7:0]}.
- sccb_req  out  1  write request to the SCCB master.
- sccb_ready  in  1  SCCB master idle and able to accept a request.
- sccb_dev_id  out  8  constant DEV_ID.
- sccb_reg  out  8  register address of the current write.
- sccb_data  out  8  data byte of the current write.
- sccb_done  in  1  one-cycle pulse when the SCCB master has finished the current write, including the stop condition.
- cfg_busy  out  1  high while a pass is in progress.
- cfg_done  out  1  sticky: pass ended on the end token.
- cfg_err  out  1  sticky: pass ended at ROM_LAST without an end token.
- entry_count  out  8  number of SCCB writes completed in the current pass.

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All of the following are 0: rom_addr, sccb_req, sccb_reg, sccb_data, cfg_busy, cfg_done, cfg_err, entry_count. Delay and gap counters are 0. sccb_dev_id is always DEV_ID.
- Reset asserted mid-pass: sccb_req drops immediately. No state is retained. A new start is needed after release.
- States: IDLE, FETCH, DECODE, REQ, WAIT_DONE, DELAY, GAP, FINISH.
- IDLE → FETCH on start=1:
  - rom_addr←0, entry_count←0, cfg_done←0, cfg_err←0, cfg_busy←1.
  - start in any other state is ignored.
- FETCH: holds for exactly one cycle (ROM latency), then goes to DECODE.
- DECODE, checked in priority order:
  - rom_data==16'hFFFF → FINISH with cfg_done←1.
  - rom_data[15:8]==8'hFF (delay token) → DELAY; load counter = rom_data[7:0] × DELAY_UNIT, computed 32 bits wide.
  - Otherwise → REQ; latch sccb_reg←rom_data[15:8] and sccb_data←rom_data[7:0].
- REQ:
  - sccb_req=1, with sccb_reg and sccb_data stable.
  - The request is accepted on a cycle where sccb_req&&sccb_ready.
  - Next cycle sccb_req=0 and state → WAIT_DONE.
  - sccb_req never rises and falls without an acceptance.
- WAIT_DONE:
  - On sccb_done → GAP, entry_count+1 (saturates at 255).
  - A sccb_done received in any other state is ignored.
- DELAY:
  - Counts down to 0, then advances.
  - A delay value of 0 gives exactly one DELAY cycle.
  - No SCCB traffic during DELAY; entry_count is unchanged.
- GAP: counts GAP_CYCLES cycles, then advances.
- Advance, from DELAY or GAP:
  - If rom_addr==ROM_LAST → FINISH with cfg_err←1.
  - Otherwise rom_addr+1 → FETCH.
- FINISH: cfg_busy←0 → IDLE. cfg_done and cfg_err hold until the next start.
- Write 0x12_80 (soft reset) receives no special handling. The ROM must follow it with a delay token (FF_F0 = 240 ms).
- Latency:
  - start to first sccb_req: 3 cycles (IDLE→FETCH→DECODE→REQ).
  - sccb_done to next sccb_req: GAP_CYCLES + 3 cycles.

Test Plan:
- ROM {12_80, FF_02, 12_14, FFFF}, DELAY_UNIT=10, GAP_CYCLES=4, ready always high, done 20 cycles after accept → exactly two writes (reg 12/data 80, then 12/14) separated by ≥20 idle delay cycles; cfg_done=1, entry_count=2, cfg_err=0.
- sccb_ready held low for 50 cycles during REQ → sccb_req stays high with sccb_reg and sccb_data stable for all 50 cycles; accepted on the first ready cycle and dropped the following cycle.
- ROM filled with 0x3A04 and no end token, ROM_LAST=8'd7 → 8 writes, then cfg_err=1, cfg_done=0, cfg_busy=0, rom_addr=7.
- reset pulled low during WAIT_DONE of the 3rd entry → sccb_req, cfg_busy, and entry_count are 0 in the same cycle. After release, IDLE with no request until the next start.
- start pulsed during a pass, plus a spurious sccb_done in GAP → neither affects the sequence; entry_count increments only once per real write.
- Delay token FF_00 → a single DELAY cycle, then the next entry is fetched; a 0 ms delay causes no stall.
